// File: rtl/request_framer_if.sv
// Byte-in / frame-out bundle between the UART receiver side and the request framer.
// Latency: none (wires only).
// Backpressure: none; rx_done is a single-cycle strobe and every output is a pulse or a held register.
interface request_framer_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] cmd_out;
  logic [4:0] addr_out;
  logic       req_valid;
  logic       err_addr;
  logic       err_timeout;
  logic       busy;

  // Byte source (UART receiver / testbench) side
  modport master (
    output rx_data, rx_done,
    input  cmd_out, addr_out, req_valid, err_addr, err_timeout, busy
  );

  // Framer side
  modport slave (
    input  rx_data, rx_done,
    output cmd_out, addr_out, req_valid, err_addr, err_timeout, busy
  );
endinterface

// File: rtl/request_framer.sv
// Assembles two-byte {command, address} request frames from a UART byte stream; optional
// inter-byte timeout built only when REQUEST_FRAMER_TIMEOUT_EN is defined.
// Latency: req_valid/err_addr one clk after the address byte's rx_done; no backpressure (never stalls rx).
module request_framer #(
  parameter int NUM_SENSORS    = 8,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset_n,
  request_framer_if.slave   bus
);

  // Addresses are 5 bits, so 1..32 sensors; a timeout window must be at least one cycle.
  if (NUM_SENSORS < 1 || NUM_SENSORS > 32) begin : g_bad_num_sensors
    $error("request_framer: NUM_SENSORS out of range 1..32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("request_framer: TIMEOUT_CYCLES must be >= 1");
  end

  localparam logic [5:0] NUM_SENSORS_W = 6'(NUM_SENSORS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    DELIVER   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cmd_lat_q, cmd_lat_d;     // command byte of the frame in progress
  logic [7:0] cmd_out_q, cmd_out_d;
  logic [4:0] addr_out_q, addr_out_d;
  logic       req_valid_q, req_valid_d;
  logic       err_addr_q, err_addr_d;

  logic       byte_nonzero;
  logic       addr_in_range;

  assign byte_nonzero  = (bus.rx_data != 8'h00);
  assign addr_in_range = ({1'b0, bus.rx_data[4:0]} < NUM_SENSORS_W);

`ifdef REQUEST_FRAMER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_timeout_q, err_timeout_d;
  logic             cnt_expired;

  assign cnt_expired = (cnt_q == CNT_LAST);
`endif

  // Next-state, output-register and counter update logic
  always_comb begin
    state_d     = state_q;
    cmd_lat_d   = cmd_lat_q;
    cmd_out_d   = cmd_out_q;
    addr_out_d  = addr_out_q;
    req_valid_d = 1'b0;
    err_addr_d  = 1'b0;
`ifdef REQUEST_FRAMER_TIMEOUT_EN
    err_timeout_d = 1'b0;
`endif

    case (state_q)
      // DELIVER treats a same-cycle byte exactly like IDLE so a back-to-back command is not lost.
      IDLE, DELIVER: begin
        state_d = IDLE;
        if (bus.rx_done && byte_nonzero) begin
          cmd_lat_d = bus.rx_data;
          state_d   = WAIT_ADDR;
        end
      end

      WAIT_ADDR: begin
        // An arriving byte always wins over an expiring timeout.
        if (bus.rx_done) begin
          if (addr_in_range) begin
            cmd_out_d   = cmd_lat_q;
            addr_out_d  = bus.rx_data[4:0];
            req_valid_d = 1'b1;
            state_d     = DELIVER;
          end else begin
            err_addr_d = 1'b1;
            state_d    = IDLE;
          end
        end
`ifdef REQUEST_FRAMER_TIMEOUT_EN
        else if (cnt_expired) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
`endif
      end

      default: state_d = IDLE;
    endcase

`ifdef REQUEST_FRAMER_TIMEOUT_EN
    // Counts cycles spent in WAIT_ADDR; zero on every entry.
    if (state_q == WAIT_ADDR && state_d == WAIT_ADDR) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
`endif
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_lat_q   <= 8'h00;
      cmd_out_q   <= 8'h00;
      addr_out_q  <= 5'd0;
      req_valid_q <= 1'b0;
      err_addr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_lat_q   <= cmd_lat_d;
      cmd_out_q   <= cmd_out_d;
      addr_out_q  <= addr_out_d;
      req_valid_q <= req_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

`ifdef REQUEST_FRAMER_TIMEOUT_EN
  // Timeout counter and its error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.cmd_out   = cmd_out_q;
  assign bus.addr_out  = addr_out_q;
  assign bus.req_valid = req_valid_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
